// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encoding and frame layout constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int HDR_BYTES = 2;
  localparam int CHK_BYTES = 1;

  // Total bytes on the wire for a frame carrying n_words instruction words.
  function automatic int frame_len(input int n_words);
    return HDR_BYTES + 4 * n_words + CHK_BYTES;
  endfunction

endpackage

// File: rtl/byte_to_word.sv
// Packs a little-endian byte stream into 32-bit words and keeps the running
// XOR checksum; word_valid pulses the cycle after the fourth byte lands.
module byte_to_word (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        lane_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0] lane;

  assign lane_last = (lane == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= 2'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
      csum       <= 8'd0;
    end else if (clear) begin
      lane       <= 2'd0;
      word_valid <= 1'b0;
      csum       <= 8'd0;
    end else begin
      word_valid <= byte_en && lane_last;
      if (byte_en) begin
        word[{lane, 3'b000} +: 8] <= byte_in;
        csum                      <= csum ^ byte_in;
        lane                      <= lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes instruction words into
// the instruction memory and releases the core once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  state_t          state, state_next;
  logic [15:0]     count;
  logic [ADDR_W:0] word_idx;
  logic            xfer, restart, clear;
  logic            lane_last, word_valid;
  logic [31:0]     word;
  logic [7:0]      csum;

  assign in_ready = (state == HDR0) || (state == HDR1) ||
                    (state == DATA) || (state == CHK);
  assign xfer     = in_valid && in_ready;
  assign restart  = start && ((state == DONE) || (state == ERR));
  assign clear    = restart || ((state == HDR1) && xfer);

  byte_to_word u_b2w (
    .clk        (clk),
    .rst        (reset),
    .clear      (clear),
    .byte_en    (xfer && (state == DATA)),
    .byte_in    (in_data),
    .lane_last  (lane_last),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  // The write lands one cycle after the last byte; word_idx advances on that
  // write, so the CHK decision looks one word ahead.
  assign wr_en   = word_valid;
  assign wr_addr = word_idx[ADDR_W-1:0];
  assign wr_data = word;

  // NOTE: state_next is defaulted before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      HDR0: if (xfer) state_next = HDR1;
      HDR1: begin
        if (xfer) begin
          if ({in_data, count[7:0]} > 16'(DEPTH))    state_next = ERR;
          else if ({in_data, count[7:0]} == 16'd0)   state_next = CHK;
          else                                       state_next = DATA;
        end
      end
      DATA: begin
        if (xfer && lane_last && ((16'(word_idx) + 16'd1) == count))
          state_next = CHK;
      end
      CHK:  if (xfer) state_next = (in_data == csum) ? DONE : ERR;
      DONE: if (start) state_next = HDR0;
      ERR:  if (start) state_next = HDR0;
      default: state_next = HDR0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HDR0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      core_rst <= (state_next != DONE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 16'd0;
      word_idx <= '0;
    end else begin
      if (restart)                        count       <= 16'd0;
      else if ((state == HDR0) && xfer)   count[7:0]  <= in_data;
      else if ((state == HDR1) && xfer)   count[15:8] <= in_data;

      if (clear)           word_idx <= '0;
      else if (word_valid) word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good, bad-checksum, oversize,
// empty, throttled and reset-interrupted frames.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_rst;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  bit throttle = 1'b0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  // Payload XOR: 20^08^00^05^20^09^00^07 = 0x03.
  localparam logic [7:0] GOOD [11] = '{8'h02, 8'h00,
                                       8'h20, 8'h08, 8'h00, 8'h05,
                                       8'h20, 8'h09, 8'h00, 8'h07,
                                       8'h03};
  logic [7:0] frame [11];

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (throttle) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < 11; i++) send(frame[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"},   wa.size(), 2);
    check({tag, "_addr0"}, wa.size() > 0 ? wa[0] : 6'h3f, 6'd0);
    check({tag, "_data0"}, wd.size() > 0 ? wd[0] : 32'hx, 32'h05000820);
    check({tag, "_addr1"}, wa.size() > 1 ? wa[1] : 6'h3f, 6'd1);
    check({tag, "_data1"}, wd.size() > 1 ? wd[1] : 32'hx, 32'h07000920);
  endtask

  task automatic check_outputs(input string tag, input logic exp_rdy,
                               input logic exp_crst, input logic exp_done,
                               input logic exp_err);
    check({tag, "_in_ready"}, in_ready, exp_rdy);
    check({tag, "_core_rst"}, core_rst, exp_crst);
    check({tag, "_done"},     done,     exp_done);
    check({tag, "_error"},    error,    exp_err);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    frame    = GOOD;

    @(negedge clk);
    check_outputs("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_wr_en",   wr_en,   1'b0);
    check("rst_wr_addr", wr_addr, 6'd0);
    check("rst_wr_data", wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good N=2 frame at full rate.
    send_frame();
    check_writes("good");
    check_outputs("good", 1'b0, 1'b0, 1'b1, 1'b0);

    // Same frame, wrong checksum.
    pulse_start();
    check_outputs("restart1", 1'b1, 1'b1, 1'b0, 1'b0);
    wa.delete(); wd.delete();
    frame[10] = 8'h00;
    send_frame();
    check_writes("badchk");
    check_outputs("badchk", 1'b0, 1'b1, 1'b0, 1'b1);

    // Oversize word count 0x41 > 64.
    pulse_start();
    wa.delete(); wd.delete();
    send(8'h41);
    send(8'h00);
    check_outputs("oversize", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("oversize_nwr", wa.size(), 0);

    // Empty frame, then restart from DONE.
    pulse_start();
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("empty_nwr", wa.size(), 0);
    check_outputs("empty", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    check_outputs("restart2", 1'b1, 1'b1, 1'b0, 1'b0);

    // Throttled good frame, then valid held high while in DONE.
    frame    = GOOD;
    throttle = 1'b1;
    send_frame();
    throttle = 1'b0;
    check_writes("throttled");
    check_outputs("throttled", 1'b0, 1'b0, 1'b1, 1'b0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs("hold_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("hold_done_nwr", wa.size(), 2);
    in_valid = 1'b0;

    // Reset after five payload bytes, then a full good frame.
    pulse_start();
    wa.delete(); wd.delete();
    for (int i = 0; i < 7; i++) send(frame[i]);
    check("midreset_prewrites", wa.size(), 1);
    #2 reset = 1'b1;
    #1;
    check_outputs("midreset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("midreset_wr_en",   wr_en,   1'b0);
    check("midreset_wr_addr", wr_addr, 6'd0);
    check("midreset_wr_data", wr_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wa.delete(); wd.delete();
    @(negedge clk);
    send_frame();
    check_writes("resend");
    check_outputs("resend", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
